dcache_wt: RTL

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the cpu data port (MemRd, MemWr, dataAddr, datain, dataout) and a slower backing data memory that uses a req/ack handshake.
- Absorbs backing-memory latency and raises mem_stall, which the team will OR into the pipeline stall network.
- One-word lines.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_array.sv | 42 ++++
 rtl/dcache_wt.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the write-through data cache: state encoding, default
// geometry and a saturating-increment helper for the optional stats counters.
package dcache_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int INDEX_BITS_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/data/valid storage: combinational lookup, one synchronous
// write port. Only the valid bits are reset.
module dcache_array import dcache_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INDEX_BITS-1:0]    ridx,
  input  logic [ADDR_W-INDEX_BITS-1:0] rtag,
  output logic                     hit,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     we,
  input  logic [INDEX_BITS-1:0]    widx,
  input  logic [ADDR_W-INDEX_BITS-1:0] wtag,
  input  logic [DATA_W-1:0]        wdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  valid       <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign hit   = valid[ridx] && (tags[ridx] == rtag);
  assign rdata = data[ridx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with a req/ack
// backing port. Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_wt import dcache_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DCACHE_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  input  logic              mem_ack
);

  localparam int TAG_W = ADDR_W - INDEX_BITS;

  state_t              state, nstate;
  logic                hit, fill_we, arr_we;
  logic [DATA_W-1:0]   line_data, rdcap, arr_wdata;
  logic [INDEX_BITS-1:0] arr_idx;
  logic [TAG_W-1:0]    arr_tag;
  logic                rd_req;

  assign rd_req = MemRd && !MemWr;

  // Fills are indexed by the latched request address, not the live cpu bus.
  assign fill_we   = (state == ST_FILL) && mem_ack;
  assign arr_we    = fill_we || ((state == ST_IDLE) && MemWr && hit);
  assign arr_idx   = fill_we ? mem_addr[INDEX_BITS-1:0] : dataAddr[INDEX_BITS-1:0];
  assign arr_tag   = fill_we ? mem_addr[ADDR_W-1:INDEX_BITS] : dataAddr[ADDR_W-1:INDEX_BITS];
  assign arr_wdata = fill_we ? mem_rdata : datain;

  dcache_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_BITS(INDEX_BITS)) u_array (
    .clk   (clk),
    .reset (reset),
    .ridx  (dataAddr[INDEX_BITS-1:0]),
    .rtag  (dataAddr[ADDR_W-1:INDEX_BITS]),
    .hit   (hit),
    .rdata (line_data),
    .we    (arr_we),
    .widx  (arr_idx),
    .wtag  (arr_tag),
    .wdata (arr_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (MemWr) nstate = ST_WRITE;
                else if (MemRd && !hit) nstate = ST_FILL;
      ST_FILL:  if (mem_ack) nstate = ST_DONE;
      ST_WRITE: if (mem_ack) nstate = ST_DONE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Reset gating keeps stall/dataout quiet even if the cpu drives requests during reset.
  always_comb begin
    mem_stall = 1'b0;
    dataout   = '0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          mem_stall = MemWr || (MemRd && !hit);
          if (rd_req && hit) dataout = line_data;
        end
        ST_FILL, ST_WRITE: mem_stall = 1'b1;
        default: dataout = rdcap;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdcap     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MemWr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= dataAddr;
            mem_wdata <= datain;
            rdcap     <= '0;
          end else if (MemRd && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= dataAddr;
          end
        end
        ST_FILL: if (mem_ack) begin
          mem_req <= 1'b0;
          rdcap   <= mem_rdata;
        end
        ST_WRITE: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((state == ST_IDLE) && rd_req) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule
